// File: rtl/ibex_csr_trace_pkg.sv
// Shared types for the CSR access tracker: op encoding, the captured trace entry and the
// post-access value helper.
package ibex_csr_trace_pkg;

    typedef enum logic [1:0] {
        CsrOpRead  = 2'd0,
        CsrOpWrite = 2'd1,
        CsrOpSet   = 2'd2,
        CsrOpClear = 2'd3
    } csr_op_e;

    // Width of the stored sequence field; the top-level SeqW is cast to this width.
    localparam int unsigned CsrSeqW = 16;

    typedef struct packed {
        logic [11:0]        addr;
        csr_op_e            op;
        logic [31:0]        wdata;
        logic [31:0]        rdata;
        logic [31:0]        newval;
        logic [CsrSeqW-1:0] seq;
        logic               gap;
    } csr_trace_entry_t;

    function automatic logic [31:0] csr_newval(csr_op_e op, logic [31:0] wdata,
                                               logic [31:0] rdata);
        logic [31:0] val;
        val = rdata;
        unique case (op)
            CsrOpRead:  val = rdata;
            CsrOpWrite: val = wdata;
            CsrOpSet:   val = rdata | wdata;
            CsrOpClear: val = rdata & ~wdata;
            default:    val = rdata;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/ibex_csr_trace_fifo.sv
// Depth-deep FIFO of CSR trace entries. Pointers carry one extra wrap bit so full and
// empty are distinguished without a counter; the head is read straight from storage.
module ibex_csr_trace_fifo
    import ibex_csr_trace_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  csr_trace_entry_t data_i,
    input  logic             pop_i,
    output csr_trace_entry_t data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    csr_trace_entry_t r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                     (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
    assign w_pop   = pop_i & ~w_empty;
    // When full, a push is only legal alongside a pop; it reuses the slot being vacated.
    assign w_push  = push_i & (~w_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AddrW-1:0]] <= data_i;
                r_wr_ptr                   <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
        end
    end

    assign data_o  = r_mem[r_rd_ptr[AddrW-1:0]];
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

// File: rtl/ibex_csr_access_tracker.sv
// Captures qualified CSR accesses, computes the post-access value, tags them with a
// sequence number and buffers them; overflow drops are counted and flagged on the next entry.
module ibex_csr_access_tracker
    import ibex_csr_trace_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned SeqW  = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            csr_access_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [31:0]     csr_wdata_i,
    input  logic [31:0]     csr_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [11:0]     out_addr_o,
    output logic [1:0]      out_op_o,
    output logic [31:0]     out_wdata_o,
    output logic [31:0]     out_rdata_o,
    output logic [31:0]     out_newval_o,
    output logic [SeqW-1:0] out_seq_o,
    output logic            out_gap_o,
    output logic [15:0]     drop_cnt_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [SeqW-1:0]  r_seq;
    logic             r_gap_pend;
    logic [15:0]      r_drop_cnt;

    logic             w_qual;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    csr_op_e          w_op;
    csr_trace_entry_t w_entry;
    csr_trace_entry_t w_head;

    assign w_qual = en_i & csr_access_i;
    assign w_pop  = ~w_empty & out_ready_i;
    assign w_push = w_qual & (~w_full | w_pop);
    assign w_drop = w_qual & w_full & ~w_pop;
    assign w_op   = csr_op_e'(csr_op_i);

    always_comb begin
        w_entry        = '0;
        w_entry.addr   = csr_addr_i;
        w_entry.op     = w_op;
        w_entry.wdata  = csr_wdata_i;
        w_entry.rdata  = csr_rdata_i;
        w_entry.newval = csr_newval(w_op, csr_wdata_i, csr_rdata_i);
        w_entry.seq    = CsrSeqW'(r_seq);
        w_entry.gap    = r_gap_pend;
    end

    // Sequence advances on every qualified access so consumers can see exactly which were lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seq      <= '0;
            r_gap_pend <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_qual) begin
                r_seq <= r_seq + SeqW'(1);
            end
            if (w_drop) begin
                r_gap_pend <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (w_push) begin
                r_gap_pend <= 1'b0;
            end
        end
    end

    ibex_csr_trace_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign out_valid_o  = ~w_empty;
    assign out_addr_o   = w_head.addr;
    assign out_op_o     = w_head.op;
    assign out_wdata_o  = w_head.wdata;
    assign out_rdata_o  = w_head.rdata;
    assign out_newval_o = w_head.newval;
    assign out_seq_o    = SeqW'(w_head.seq);
    assign out_gap_o    = w_head.gap;
    assign drop_cnt_o   = r_drop_cnt;
    assign full_o       = w_full;
    assign empty_o      = w_empty;

endmodule

// File: tb/tb_ibex_csr_access_tracker.sv
// Scoreboard bench for ibex_csr_access_tracker: directed accesses push expected entries,
// a negedge monitor pops and compares each accepted output entry.
module tb_ibex_csr_access_tracker;
    import ibex_csr_trace_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        en_i;
    logic        csr_access_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [11:0] out_addr_o;
    logic [1:0]  out_op_o;
    logic [31:0] out_wdata_o;
    logic [31:0] out_rdata_o;
    logic [31:0] out_newval_o;
    logic [15:0] out_seq_o;
    logic        out_gap_o;
    logic [15:0] drop_cnt_o;
    logic        full_o;
    logic        empty_o;

    int n_checks = 0;
    int n_pass   = 0;
    csr_trace_entry_t exp_q [$];

    ibex_csr_access_tracker #(
        .Depth (8),
        .SeqW  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .csr_access_i (csr_access_i),
        .csr_addr_i   (csr_addr_i),
        .csr_op_i     (csr_op_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_i  (csr_rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_addr_o   (out_addr_o),
        .out_op_o     (out_op_o),
        .out_wdata_o  (out_wdata_o),
        .out_rdata_o  (out_rdata_o),
        .out_newval_o (out_newval_o),
        .out_seq_o    (out_seq_o),
        .out_gap_o    (out_gap_o),
        .drop_cnt_o   (drop_cnt_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a handshake seen at negedge is consumed at the following posedge.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            csr_trace_entry_t act;
            act.addr   = out_addr_o;
            act.op     = csr_op_e'(out_op_o);
            act.wdata  = out_wdata_o;
            act.rdata  = out_rdata_o;
            act.newval = out_newval_o;
            act.seq    = out_seq_o;
            act.gap    = out_gap_o;
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", {111'd0, act.seq, act.gap}, 128'hFFFF_FFFF);
            end else begin
                chk($sformatf("entry_seq%0d", exp_q[0].seq), 128'(act), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic expect_e(input logic [11:0] addr, input logic [1:0] op,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input logic [31:0] nv, input logic [15:0] seq, input logic gap);
        csr_trace_entry_t e;
        e.addr = addr; e.op = csr_op_e'(op); e.wdata = wd; e.rdata = rd;
        e.newval = nv; e.seq = seq; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic access(input logic [11:0] addr, input logic [1:0] op,
                          input logic [31:0] wd, input logic [31:0] rd);
        en_i = 1'b1; csr_access_i = 1'b1;
        csr_addr_i = addr; csr_op_i = op; csr_wdata_i = wd; csr_rdata_i = rd;
        @(posedge clk_i); #1;
        csr_access_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk_i);
        #1;
        chk("drain_left", 128'(exp_q.size()), 128'd0);
        chk("drain_empty", 128'(empty_o), 128'd1);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; csr_access_i = 1'b0; out_ready_i = 1'b0;
        csr_addr_i = '0; csr_op_i = '0; csr_wdata_i = '0; csr_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 128'(out_valid_o), 128'd0);
        chk("rst_empty", 128'(empty_o), 128'd1);
        chk("rst_full", 128'(full_o), 128'd0);
        chk("rst_drop", 128'(drop_cnt_o), 128'd0);
        chk("rst_gap", 128'(out_gap_o), 128'd0);
        chk("rst_newval", 128'(out_newval_o), 128'd0);
        rst_ni = 1'b1;

        // Single WRITE
        out_ready_i = 1'b1;
        expect_e(12'h300, 2'd1, 32'h8, 32'h1800, 32'h8, 16'd0, 1'b0);
        access(12'h300, 2'd1, 32'h8, 32'h1800);
        chk("write_latency_valid", 128'(out_valid_o), 128'd1);
        wait_drain();

        // SET then CLEAR
        do_reset();
        out_ready_i = 1'b1;
        expect_e(12'h304, 2'd2, 32'h0F, 32'hF0, 32'hFF, 16'd0, 1'b0);
        expect_e(12'h304, 2'd3, 32'h0F, 32'hFF, 32'hF0, 16'd1, 1'b0);
        access(12'h304, 2'd2, 32'h0F, 32'hF0);
        access(12'h304, 2'd3, 32'h0F, 32'hFF);
        wait_drain();

        // Overflow: 10 accesses into 8 entries
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++)
            expect_e(12'h340 + 12'(i), 2'd1, 32'h11 * i, 32'h0, 32'h11 * i, 16'(i), 1'b0);
        for (int i = 0; i < 10; i++) access(12'h340 + 12'(i), 2'd1, 32'h11 * i, 32'h0);
        chk("ovf_full", 128'(full_o), 128'd1);
        chk("ovf_drop", 128'(drop_cnt_o), 128'd2);
        out_ready_i = 1'b1;
        wait_drain();
        chk("ovf_full_after", 128'(full_o), 128'd0);
        expect_e(12'h350, 2'd0, 32'h0, 32'hABCD, 32'hABCD, 16'd10, 1'b1);
        access(12'h350, 2'd0, 32'h0, 32'hABCD);
        wait_drain();
        chk("ovf_drop_hold", 128'(drop_cnt_o), 128'd2);

        // Full with simultaneous push and pop
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 9; i++)
            expect_e(12'h7B0, 2'd2, 32'h1 << i, 32'h100, 32'h100 | (32'h1 << i), 16'(i), 1'b0);
        for (int i = 0; i < 8; i++) access(12'h7B0, 2'd2, 32'h1 << i, 32'h100);
        chk("pp_full_before", 128'(full_o), 128'd1);
        out_ready_i = 1'b1;
        access(12'h7B0, 2'd2, 32'h1 << 8, 32'h100);
        out_ready_i = 1'b0;
        chk("pp_full_after", 128'(full_o), 128'd1);
        chk("pp_no_drop", 128'(drop_cnt_o), 128'd0);
        chk("pp_head_seq", 128'(out_seq_o), 128'd1);
        out_ready_i = 1'b1;
        wait_drain();

        // Disabled capture holds seq
        do_reset();
        out_ready_i = 1'b1;
        expect_e(12'hB00, 2'd0, 32'h0, 32'h5, 32'h5, 16'd0, 1'b0);
        expect_e(12'hB00, 2'd0, 32'h0, 32'h6, 32'h6, 16'd1, 1'b0);
        access(12'hB00, 2'd0, 32'h0, 32'h5);
        access(12'hB00, 2'd0, 32'h0, 32'h6);
        wait_drain();
        en_i = 1'b0; csr_access_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        csr_access_i = 1'b0;
        chk("dis_empty", 128'(empty_o), 128'd1);
        expect_e(12'hB02, 2'd1, 32'h77, 32'h0, 32'h77, 16'd2, 1'b0);
        access(12'hB02, 2'd1, 32'h77, 32'h0);
        wait_drain();

        // Asynchronous reset with 4 entries buffered
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) access(12'h341, 2'd1, 32'(i), 32'h0);
        chk("mid_valid", 128'(out_valid_o), 128'd1);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", 128'(out_valid_o), 128'd0);
        chk("arst_empty", 128'(empty_o), 128'd1);
        chk("arst_drop", 128'(drop_cnt_o), 128'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        expect_e(12'h342, 2'd3, 32'hF, 32'hFF, 32'hF0, 16'd0, 1'b0);
        access(12'h342, 2'd3, 32'hF, 32'hFF);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_csr_access_tracker.md
# ibex_csr_access_tracker

Synthesizable capture stage directly downstream of the CSR access probe signals: samples every qualified CSR access (address, op, write data, read data), computes the resulting CSR value, tags it with a sequence number and buffers it in a FIFO. Entries drain through a valid/ready stream to the DV scoreboard or trace sink. Overflow is lossy but fully accounted for with a sticky gap flag and a drop counter.

## Interface
- Depth, 8: FIFO entries; power of two, ≥2.
- SeqW, 16: sequence-number width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  capture enable.
- csr_access_i  in  1  CSR access this cycle.
- csr_addr_i  in  12  CSR address (ibex_pkg::csr_num_e).
- csr_op_i  in  2  op (ibex_pkg::csr_op_e: READ=0, WRITE=1, SET=2, CLEAR=3).
- csr_wdata_i  in  32  operand written by the instruction.
- csr_rdata_i  in  32  old CSR value.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  sink accepts head.
- out_addr_o, out_op_o, out_wdata_o, out_rdata_o  out  12/2/32/32  captured fields.
- out_newval_o  out  32  computed post-access value.
- out_seq_o  out  SeqW  sequence number of entry.
- out_gap_o  out  1  one or more accesses dropped immediately before this entry.
- drop_cnt_o  out  16  total dropped accesses, saturating.
- full_o, empty_o  out  1  FIFO status.

## Operation
- Qualified access: en_i & csr_access_i at a rising edge.
- newval: READ→rdata; WRITE→wdata; SET→rdata|wdata; CLEAR→rdata&~wdata; computed at capture, stored.
- seq_q increments (mod 2^SeqW) on every qualified access, stored or dropped; a stored entry carries the pre-increment value. First access after reset gets seq 0.
- Push accepted if not full, or full with pop in same cycle (out_valid_o & out_ready_i).
- Push rejected (full, no pop): drop_cnt_q += 1, saturating at 0xFFFF; gap_pend_q set.
- Accepted push stores gap = gap_pend_q, then clears gap_pend_q.
- Pop: out_valid_o & out_ready_i; head advances.
- en_i low: no capture, seq_q and gap_pend_q hold; draining continues.
- Outputs are the head entry registers; when empty, out_valid_o=0 and data outputs are don't-care (implementation drives the stale head).

## Timing
- Reset values: out_valid_o=0, empty_o=1, full_o=0, drop_cnt_o=0, out_gap_o=0, seq_q=0, gap_pend_q=0, all pointers 0, data outputs 0.
- Latency: access at edge N → out_valid_o high after edge N (visible in cycle N+1); no combinational path from csr_*_i to outputs.
- Empty with simultaneous push: no bypass; entry appears next cycle.
- Full with simultaneous push and pop: both happen, stays full, no drop.
- Pointers log2(Depth)+1 bits; full = MSBs differ & LSBs equal; wrap-around is natural.
- out_valid_o and head data are stable until accepted.
- Reset asserted mid-stream: all entries discarded, counters cleared immediately (async).

## Structure
- ibex_csr_trace_pkg: csr_trace_entry_t struct (addr, op, wdata, rdata, newval, seq, gap), newval function.
- Sub-module ibex_csr_trace_fifo: generic Depth-deep FIFO of csr_trace_entry_t with push/pop/full/empty; top handles qualification, newval, seq, gap and drop logic.

## Test plan
- Single WRITE addr 0x300, wdata 0x8, rdata 0x1800, ready=1 → one entry next cycle: op=1, newval 0x8, seq 0, gap 0.
- SET then CLEAR on 0x304 (rdata 0xF0, wdata 0x0F; then rdata 0xFF, wdata 0x0F) → newval 0xFF then 0xF0, seq 0,1.
- ready=0, Depth=8, 10 consecutive accesses → full_o=1, drop_cnt_o=2; raise ready, 9th stored access seq 10 after drain with gap=1, earlier 8 entries seq 0–7 gap 0.
- Full FIFO, push and pop same cycle → no drop, full_o stays 1, popped seq n, newest stored.
- en_i=0 with csr_access_i=1 for 5 cycles → no entries, seq unchanged; next enabled access gets next seq.
- Assert rst_ni mid-drain with 4 entries → out_valid_o=0, empty_o=1, drop_cnt_o=0 immediately; next access seq 0.
